// File: rtl/ascii_to_binary.sv
// Shifts ASCII '0'/'1' characters from a UART RX stream into a binary word, MSB first.
// Each valid-strobed run of bytes is one frame; the result is held once the frame ends.
module ascii_to_binary #(
  parameter int          WIDTH     = 8,
  parameter logic [7:0]  CHAR_ZERO = 8'h30,
  parameter logic [7:0]  CHAR_ONE  = 8'h31
) (
  input  logic [7:0]       in,
  output logic [WIDTH-1:0] out,
  input  logic             clk,
  input  logic             rst,
  input  logic             w_RX_dv
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] next_out;
  logic [CW-1:0]    count, next_count;
  logic             is_digit;
  logic             digit_bit;

  assign is_digit  = (in == CHAR_ZERO) || (in == CHAR_ONE);
  assign digit_bit = (in == CHAR_ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out   <= '0;
      count <= '0;
    end else begin
      state <= next_state;
      out   <= next_out;
      count <= next_count;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (w_RX_dv)  next_state = ACCUM;
      ACCUM:   if (!w_RX_dv) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A frame start discards the previous word even when its first byte is not a digit.
  always_comb begin
    next_out   = out;
    next_count = count;
    if (w_RX_dv) begin
      if (state == IDLE) begin
        next_out   = {{(WIDTH-1){1'b0}}, is_digit & digit_bit};
        next_count = is_digit ? CW'(1) : '0;
      end else if (is_digit) begin
        next_out = {out[WIDTH-2:0], digit_bit};
        if (count != CW'(WIDTH))
          next_count = count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ascii_to_binary.sv
// Directed self-checking bench for ascii_to_binary: each task drives one scenario
// and compares out against hand-computed values one clock after each sampled byte.
module tb_ascii_to_binary;

  logic       clk;
  logic       rst;
  logic [7:0] in;
  logic [7:0] out;
  logic       w_RX_dv;

  int errors = 0;
  int checks = 0;

  ascii_to_binary dut (
    .in      (in),
    .out     (out),
    .clk     (clk),
    .rst     (rst),
    .w_RX_dv (w_RX_dv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Inputs change 1ns after a rising edge, so the next edge samples them and out is read 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; w_RX_dv = 1'b0; in = 8'h00;
    step(); step();
    checks++;
    if (out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_value: out=%h expected=%h", out, 8'h00);
    end
    rst = 1'b0;
    step(); step();
    checks++;
    if (out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_hold: out=%h expected=%h", out, 8'h00);
    end
  endtask

  task automatic test_frame_101();
    logic [7:0] bytes [3] = '{8'h31, 8'h30, 8'h31};
    logic [7:0] exp   [3] = '{8'h01, 8'h02, 8'h05};
    for (int i = 0; i < 3; i++) begin
      in = bytes[i]; w_RX_dv = 1'b1;
      step();
      checks++;
      if (out !== exp[i]) begin
        errors++;
        $display("[TB] FAIL frame101_byte%0d: out=%h expected=%h", i, out, exp[i]);
      end
    end
    w_RX_dv = 1'b0; in = 8'h31;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out !== 8'h05) begin
        errors++;
        $display("[TB] FAIL frame101_hold%0d: out=%h expected=%h", i, out, 8'h05);
      end
    end
  endtask

  task automatic test_second_frame();
    logic [7:0] exp [2] = '{8'h01, 8'h03};
    for (int i = 0; i < 2; i++) begin
      in = 8'h31; w_RX_dv = 1'b1;
      step();
      checks++;
      if (out !== exp[i]) begin
        errors++;
        $display("[TB] FAIL second_frame_byte%0d: out=%h expected=%h", i, out, exp[i]);
      end
    end
    w_RX_dv = 1'b0;
    step();
  endtask

  task automatic test_non_digit();
    logic [7:0] bytes [3] = '{8'h31, 8'h41, 8'h31};
    logic [7:0] exp   [3] = '{8'h01, 8'h01, 8'h03};
    for (int i = 0; i < 3; i++) begin
      in = bytes[i]; w_RX_dv = 1'b1;
      step();
      checks++;
      if (out !== exp[i]) begin
        errors++;
        $display("[TB] FAIL non_digit_byte%0d: out=%h expected=%h", i, out, exp[i]);
      end
    end
    w_RX_dv = 1'b0;
    step();
    // A frame whose first byte is not a digit still clears the held word.
    in = 8'h41; w_RX_dv = 1'b1;
    step();
    checks++;
    if (out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL non_digit_start: out=%h expected=%h", out, 8'h00);
    end
    in = 8'h31;
    step();
    checks++;
    if (out !== 8'h01) begin
      errors++;
      $display("[TB] FAIL non_digit_start_next: out=%h expected=%h", out, 8'h01);
    end
    w_RX_dv = 1'b0;
    step();
  endtask

  task automatic test_overflow();
    logic [7:0] bytes [10] = '{8'h31, 8'h31, 8'h31, 8'h31, 8'h31,
                               8'h31, 8'h31, 8'h31, 8'h30, 8'h30};
    for (int i = 0; i < 10; i++) begin
      in = bytes[i]; w_RX_dv = 1'b1;
      step();
      if (i == 7) begin
        checks++;
        if (out !== 8'hFF) begin
          errors++;
          $display("[TB] FAIL overflow_full: out=%h expected=%h", out, 8'hFF);
        end
      end
    end
    checks++;
    if (out !== 8'hFC) begin
      errors++;
      $display("[TB] FAIL overflow_final: out=%h expected=%h", out, 8'hFC);
    end
    w_RX_dv = 1'b0;
    step();
    checks++;
    if (out !== 8'hFC) begin
      errors++;
      $display("[TB] FAIL overflow_hold: out=%h expected=%h", out, 8'hFC);
    end
  endtask

  task automatic test_reset_mid_frame();
    in = 8'h31; w_RX_dv = 1'b1;
    step(); step();
    checks++;
    if (out !== 8'h03) begin
      errors++;
      $display("[TB] FAIL midreset_pre: out=%h expected=%h", out, 8'h03);
    end
    rst = 1'b1;
    step();
    checks++;
    if (out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midreset_clear: out=%h expected=%h", out, 8'h00);
    end
    rst = 1'b0;
    step();
    checks++;
    if (out !== 8'h01) begin
      errors++;
      $display("[TB] FAIL midreset_restart: out=%h expected=%h", out, 8'h01);
    end
    in = 8'h30;
    step();
    checks++;
    if (out !== 8'h02) begin
      errors++;
      $display("[TB] FAIL midreset_continue: out=%h expected=%h", out, 8'h02);
    end
    w_RX_dv = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; w_RX_dv = 1'b0; in = 8'h00;
    test_reset();
    test_frame_101();
    test_second_frame();
    test_non_digit();
    test_overflow();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
